i2s_rx: RTL and testbench

//   I2S slave receiver: recovers stereo PCM samples from an external I2S stream (sclk/ws/sd).
//   The pins are asynchronous to clk. Samples are presented to OPL3 fabric as parallel words.
//   It is the receive counterpart of the I2S transmitter: standard I2S framing, MSB first,
//   ws low = left, ws high = right, MSB one sclk after each ws transition.

---
 rtl/i2s_rx.sv | 138 +++++++++++++
 tb/tb_i2s_rx.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// I2S slave receiver.
// Recovers stereo PCM words from an asynchronous I2S stream (sclk/ws/sd),
// MSB first, one sclk after each ws transition; ws low = left, ws high = right.
// A left/right pair is presented on a single-cycle sample_valid pulse once both
// slots of a frame held at least SAMPLE_WIDTH bits; short slots raise frame_error.
module i2s_rx #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i2s_sclk,
    input  logic                    i2s_ws,
    input  logic                    i2s_sd,
    output logic [SAMPLE_WIDTH-1:0] left_channel,
    output logic [SAMPLE_WIDTH-1:0] right_channel,
    output logic                    sample_valid,
    output logic                    frame_error,
    output logic                    locked
);

    localparam int CW = $clog2(SAMPLE_WIDTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(SAMPLE_WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0]  sclk_sync_q;
    logic [SYNC_STAGES-1:0]  ws_sync_q;
    logic [SYNC_STAGES-1:0]  sd_sync_q;
    logic                    sclk_prev_q;
    logic                    ws_d_q;
    logic [CW-1:0]           bit_cnt_q;
    logic [SAMPLE_WIDTH-1:0] shift_q;
    logic [SAMPLE_WIDTH-1:0] left_hold_q;
    logic                    left_ok_q;
    logic                    left_seen_q;
    state_t                  state_q;

    logic                    sclk_s;
    logic                    ws_s;
    logic                    sd_s;
    logic                    sclk_rise;
    logic                    ws_edge;
    logic                    shift_room;
    logic [SAMPLE_WIDTH-1:0] word_d;
    logic [CW-1:0]           cnt_d;
    logic                    word_full;

    // All three pins share the same synchronizer depth so ws/sd stay aligned with sclk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            ws_sync_q   <= '0;
            sd_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i2s_sclk};
            ws_sync_q   <= {ws_sync_q[SYNC_STAGES-2:0], i2s_ws};
            sd_sync_q   <= {sd_sync_q[SYNC_STAGES-2:0], i2s_sd};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    // Rise detect plus the word/count the current rise would produce; the bit on a ws edge
    // still belongs to the slot that is ending, so it is folded in before the commit.
    always_comb begin
        sclk_s     = sclk_sync_q[SYNC_STAGES-1];
        ws_s       = ws_sync_q[SYNC_STAGES-1];
        sd_s       = sd_sync_q[SYNC_STAGES-1];
        sclk_rise  = sclk_s & ~sclk_prev_q;
        ws_edge    = sclk_rise & (ws_s != ws_d_q);
        shift_room = (bit_cnt_q < FULL_CNT);
        word_d     = shift_q;
        cnt_d      = bit_cnt_q;
        if (shift_room) begin
            word_d = {shift_q[SAMPLE_WIDTH-2:0], sd_s};
            cnt_d  = bit_cnt_q + CW'(1);
        end
        word_full  = (cnt_d == FULL_CNT);
    end

    // Capture FSM: shifts on every sclk rise, commits slots on ws edges once locked.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            ws_d_q        <= 1'b0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            left_hold_q   <= '0;
            left_ok_q     <= 1'b0;
            left_seen_q   <= 1'b0;
            left_channel  <= '0;
            right_channel <= '0;
            sample_valid  <= 1'b0;
            frame_error   <= 1'b0;
            locked        <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
            if (sclk_rise) begin
                ws_d_q    <= ws_s;
                shift_q   <= word_d;
                bit_cnt_q <= ws_edge ? '0 : cnt_d;
                if (ws_edge) begin
                    case (state_q)
                        IDLE: begin
                            state_q <= RUN;
                            locked  <= 1'b1;
                        end
                        RUN: begin
                            if (ws_s) begin
                                // Left slot ended: park it until the right slot completes.
                                left_hold_q <= word_d;
                                left_ok_q   <= word_full;
                                left_seen_q <= 1'b1;
                            end else begin
                                // Right slot ended: publish the pair or flag a short slot.
                                if (left_seen_q && left_ok_q && word_full) begin
                                    left_channel  <= left_hold_q;
                                    right_channel <= word_d;
                                    sample_valid  <= 1'b1;
                                end else if (left_seen_q) begin
                                    frame_error <= 1'b1;
                                end
                                left_seen_q <= 1'b0;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: an I2S master BFM drives framed words and a negedge
// monitor records every sample_valid / frame_error pulse for the scenario tasks.
module tb_i2s_rx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i2s_sclk = 1'b0;
    logic        i2s_ws = 1'b0;
    logic        i2s_sd = 1'b0;
    logic [15:0] left_channel;
    logic [15:0] right_channel;
    logic        sample_valid;
    logic        frame_error;
    logic        locked;

    int checks = 0;
    int failures = 0;

    logic        pend_bit = 1'b0;
    logic [15:0] vq_l[$];
    logic [15:0] vq_r[$];
    logic [15:0] eq_l[$];
    logic [15:0] eq_r[$];
    int          coincide = 0;
    int          bad_change = 0;
    logic [15:0] prev_l = '0;
    logic [15:0] prev_r = '0;

    i2s_rx #(.SAMPLE_WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i2s_sclk      (i2s_sclk),
        .i2s_ws        (i2s_ws),
        .i2s_sd        (i2s_sd),
        .left_channel  (left_channel),
        .right_channel (right_channel),
        .sample_valid  (sample_valid),
        .frame_error   (frame_error),
        .locked        (locked)
    );

    always #5 clk = ~clk;

    // Monitor: log pulses and catch outputs changing without a valid pulse.
    always @(negedge clk) begin
        if (sample_valid) begin
            vq_l.push_back(left_channel);
            vq_r.push_back(right_channel);
        end
        if (frame_error) begin
            eq_l.push_back(left_channel);
            eq_r.push_back(right_channel);
        end
        if (sample_valid && frame_error) coincide++;
        if (reset_n && !sample_valid && (left_channel !== prev_l || right_channel !== prev_r))
            bad_change++;
        prev_l = left_channel;
        prev_r = right_channel;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        vq_l.delete();
        vq_r.delete();
        eq_l.delete();
        eq_r.delete();
    endtask

    // One sclk period: ws/sd change with the falling edge, sampled on the rising edge.
    task automatic send_period(input logic w, input logic d, input int h);
        i2s_sclk = 1'b0;
        i2s_ws   = w;
        i2s_sd   = d;
        wait_clks(h);
        i2s_sclk = 1'b1;
        wait_clks(h);
    endtask

    // A slot of nbits periods; data is delayed one period (the I2S one-bit offset).
    task automatic send_slot(input logic w, input logic [15:0] v, input int nbits,
                             input int stall_k, input int h);
        logic b;
        int   nv;
        logic [15:0] hl;
        for (int k = 0; k < nbits; k++) begin
            b = (k < 16) ? v[15-k] : 1'b0;
            if (k == stall_k) begin
                i2s_sclk = 1'b0;
                nv = vq_l.size();
                hl = left_channel;
                wait_clks(1000);
                checks++;
                if (vq_l.size() !== nv) begin
                    failures++;
                    $display("FAIL stall_no_valid: got %0d pulses, expected %0d", vq_l.size(), nv);
                end
                checks++;
                if (left_channel !== hl || locked !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_hold: left=%h locked=%b, expected left=%h locked=1",
                             left_channel, locked, hl);
                end
            end
            send_period(w, pend_bit, h);
            pend_bit = b;
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int slot,
                              input int rbits, input int h);
        send_slot(1'b0, l, slot, -1, h);
        send_slot(1'b1, r, rbits, -1, h);
    endtask

    // Final ws 1->0 edge that closes the last right slot, then let the pulse land.
    task automatic send_tail(input int h);
        send_period(1'b0, pend_bit, h);
        i2s_sclk = 1'b0;
        wait_clks(h + 4);
    endtask

    // Reset, then a short ws-high preamble so the first edge locks before frame 1.
    task automatic start(input int h);
        reset_n  = 1'b0;
        i2s_sclk = 1'b0;
        i2s_ws   = 1'b0;
        i2s_sd   = 1'b0;
        wait_clks(3);
        reset_n = 1'b1;
        wait_clks(2);
        clear_logs();
        send_period(1'b1, 1'b0, h);
        send_period(1'b1, 1'b0, h);
        pend_bit = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wait_clks(4);
        checks++;
        if (left_channel !== 16'h0 || right_channel !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h/%h, expected 0000/0000", left_channel, right_channel);
        end
        checks++;
        if (sample_valid !== 1'b0 || frame_error !== 1'b0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: got v=%b e=%b l=%b, expected 0/0/0",
                     sample_valid, frame_error, locked);
        end
        reset_n = 1'b1;
        wait_clks(20);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL idle_unlocked: got locked=%b, expected 0", locked);
        end
        $display("test_reset done");
    endtask

    task automatic test_frames64();
        start(4);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL lock_after_edge: got locked=%b, expected 1", locked);
        end
        for (int f = 0; f < 4; f++) send_frame(16'h8001, 16'h7FFE, 32, 32, 4);
        send_tail(4);
        checks++;
        if (vq_l.size() !== 4) begin
            failures++;
            $display("FAIL f64_count: got %0d pulses, expected 4", vq_l.size());
        end
        for (int i = 0; i < vq_l.size(); i++) begin
            checks++;
            if (vq_l[i] !== 16'h8001 || vq_r[i] !== 16'h7FFE) begin
                failures++;
                $display("FAIL f64_word%0d: got %h/%h, expected 8001/7FFE", i, vq_l[i], vq_r[i]);
            end
        end
        checks++;
        if (eq_l.size() !== 0) begin
            failures++;
            $display("FAIL f64_err: got %0d errors, expected 0", eq_l.size());
        end
        $display("test_frames64 done: %0d pulses", vq_l.size());
    endtask

    task automatic test_frames32();
        start(4);
        for (int f = 0; f < 4; f++) send_frame(16'hA5A5, 16'h5A5A, 16, 16, 4);
        send_tail(4);
        checks++;
        if (vq_l.size() !== 4) begin
            failures++;
            $display("FAIL f32_count: got %0d pulses, expected 4", vq_l.size());
        end
        for (int i = 0; i < vq_l.size(); i++) begin
            checks++;
            if (vq_l[i] !== 16'hA5A5 || vq_r[i] !== 16'h5A5A) begin
                failures++;
                $display("FAIL f32_word%0d: got %h/%h, expected A5A5/5A5A", i, vq_l[i], vq_r[i]);
            end
        end
        checks++;
        if (eq_l.size() !== 0) begin
            failures++;
            $display("FAIL f32_err: got %0d errors, expected 0", eq_l.size());
        end
        $display("test_frames32 done: %0d pulses", vq_l.size());
    endtask

    task automatic test_short_slot();
        logic [15:0] exp_l[3] = '{16'h1111, 16'h3333, 16'h7777};
        logic [15:0] exp_r[3] = '{16'h2222, 16'h4444, 16'h8888};
        start(4);
        send_frame(16'h1111, 16'h2222, 16, 16, 4);
        send_frame(16'h3333, 16'h4444, 16, 16, 4);
        send_frame(16'h5555, 16'h6666, 16, 12, 4);
        send_frame(16'h7777, 16'h8888, 16, 16, 4);
        send_tail(4);
        checks++;
        if (vq_l.size() !== 3) begin
            failures++;
            $display("FAIL short_count: got %0d pulses, expected 3", vq_l.size());
        end
        for (int i = 0; i < 3 && i < vq_l.size(); i++) begin
            checks++;
            if (vq_l[i] !== exp_l[i] || vq_r[i] !== exp_r[i]) begin
                failures++;
                $display("FAIL short_word%0d: got %h/%h, expected %h/%h",
                         i, vq_l[i], vq_r[i], exp_l[i], exp_r[i]);
            end
        end
        checks++;
        if (eq_l.size() !== 1) begin
            failures++;
            $display("FAIL short_err_count: got %0d errors, expected 1", eq_l.size());
        end else begin
            checks++;
            if (eq_l[0] !== 16'h3333 || eq_r[0] !== 16'h4444) begin
                failures++;
                $display("FAIL short_hold: got %h/%h, expected 3333/4444", eq_l[0], eq_r[0]);
            end
        end
        $display("test_short_slot done: %0d pulses %0d errors", vq_l.size(), eq_l.size());
    endtask

    task automatic test_reset_midframe();
        start(4);
        send_frame(16'h1234, 16'h5678, 16, 16, 4);
        send_slot(1'b0, 16'h9ABC, 16, -1, 4);
        send_slot(1'b1, 16'hDEF0, 8, -1, 4);
        checks++;
        if (left_channel !== 16'h1234 || right_channel !== 16'h5678) begin
            failures++;
            $display("FAIL pre_reset: got %h/%h, expected 1234/5678", left_channel, right_channel);
        end
        i2s_sclk = 1'b0;
        wait_clks(4);
        reset_n = 1'b0;
        #1;
        checks++;
        if (left_channel !== 16'h0 || right_channel !== 16'h0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got %h/%h locked=%b, expected 0000/0000 0",
                     left_channel, right_channel, locked);
        end
        wait_clks(3);
        reset_n = 1'b1;
        wait_clks(2);
        clear_logs();
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL relock_wait: got locked=%b, expected 0", locked);
        end
        send_slot(1'b1, 16'h0000, 8, -1, 4);
        send_frame(16'h0F0F, 16'hF0F0, 16, 16, 4);
        send_frame(16'hCAFE, 16'hBEEF, 16, 16, 4);
        send_tail(4);
        checks++;
        if (vq_l.size() !== 2 || eq_l.size() !== 0) begin
            failures++;
            $display("FAIL post_reset_count: got %0d pulses %0d errors, expected 2 and 0",
                     vq_l.size(), eq_l.size());
        end else begin
            checks++;
            if (vq_l[0] !== 16'h0F0F || vq_r[0] !== 16'hF0F0 ||
                vq_l[1] !== 16'hCAFE || vq_r[1] !== 16'hBEEF) begin
                failures++;
                $display("FAIL post_reset_words: got %h/%h %h/%h, expected 0F0F/F0F0 CAFE/BEEF",
                         vq_l[0], vq_r[0], vq_l[1], vq_r[1]);
            end
        end
        $display("test_reset_midframe done: %0d pulses", vq_l.size());
    endtask

    task automatic test_extremes();
        logic [15:0] el[20];
        logic [15:0] er[20];
        for (int i = 0; i < 16; i++) begin
            el[i] = 16'h0001 << i;
            er[i] = 16'h8000 >> i;
        end
        el[16] = 16'h0000; er[16] = 16'hFFFF;
        el[17] = 16'hFFFF; er[17] = 16'h0000;
        el[18] = 16'h8000; er[18] = 16'h7FFF;
        el[19] = 16'h7FFF; er[19] = 16'h8000;
        start(3);
        for (int f = 0; f < 20; f++) send_frame(el[f], er[f], 16, 16, 3);
        send_tail(3);
        checks++;
        if (vq_l.size() !== 20 || eq_l.size() !== 0) begin
            failures++;
            $display("FAIL ext_count: got %0d pulses %0d errors, expected 20 and 0",
                     vq_l.size(), eq_l.size());
        end
        for (int i = 0; i < 20 && i < vq_l.size(); i++) begin
            checks++;
            if (vq_l[i] !== el[i] || vq_r[i] !== er[i]) begin
                failures++;
                $display("FAIL ext_word%0d: got %h/%h, expected %h/%h",
                         i, vq_l[i], vq_r[i], el[i], er[i]);
            end
        end
        $display("test_extremes done: %0d pulses", vq_l.size());
    endtask

    task automatic test_stall();
        start(4);
        send_frame(16'h1357, 16'h2468, 16, 16, 4);
        send_slot(1'b0, 16'hACE1, 16, 5, 4);
        send_slot(1'b1, 16'hBDF0, 16, -1, 4);
        send_frame(16'h0246, 16'h8ACE, 16, 16, 4);
        send_tail(4);
        checks++;
        if (vq_l.size() !== 3 || eq_l.size() !== 0) begin
            failures++;
            $display("FAIL stall_count: got %0d pulses %0d errors, expected 3 and 0",
                     vq_l.size(), eq_l.size());
        end else begin
            checks++;
            if (vq_l[1] !== 16'hACE1 || vq_r[1] !== 16'hBDF0 ||
                vq_l[2] !== 16'h0246 || vq_r[2] !== 16'h8ACE) begin
                failures++;
                $display("FAIL stall_words: got %h/%h %h/%h, expected ACE1/BDF0 0246/8ACE",
                         vq_l[1], vq_r[1], vq_l[2], vq_r[2]);
            end
        end
        $display("test_stall done: %0d pulses", vq_l.size());
    endtask

    task automatic test_invariants();
        checks++;
        if (coincide !== 0) begin
            failures++;
            $display("FAIL valid_error_overlap: got %0d cycles, expected 0", coincide);
        end
        checks++;
        if (bad_change !== 0) begin
            failures++;
            $display("FAIL output_stability: got %0d unpulsed changes, expected 0", bad_change);
        end
    endtask

    initial begin
        test_reset();
        test_frames64();
        test_frames32();
        test_short_slot();
        test_reset_midframe();
        test_extremes();
        test_stall();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
